// File: rtl/dtc_share_arbiter.sv
// rtl/dtc_share_arbiter.sv - round-robin sharing of one combinational decision-tree classifier
module dtc_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 11,
    parameter int OUT_W = 3,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*IN_W-1:0]  req_feat,
    output logic [IN_W-1:0]       dt_inp,
    input  logic [OUT_W-1:0]      dt_outp,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [NREQ*OUT_W-1:0] rsp_class,
    output logic                  busy,
    output logic [CNT_W-1:0]      done_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_q;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [IN_W-1:0]  feat_q;
    logic [OUT_W-1:0] cls_q;
    logic             rsp_hs;

    // Search starts one past the last served requester so every waiter is reached within NREQ grants.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(rr_ptr) + k) % NREQ;
            cand_idx = IDX_W'(cand);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign rsp_hs = (state == RESP) && rsp_ready[gnt_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        rsp_class = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    state_nxt          = EVAL;
                end
            end
            EVAL: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[gnt_q]                         = 1'b1;
                rsp_class[int'(gnt_q)*OUT_W +: OUT_W] = cls_q;
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= IDX_W'(NREQ - 1);
            gnt_q    <= '0;
            feat_q   <= '0;
            cls_q    <= '0;
            done_cnt <= '0;
        end else begin
            if (state == IDLE && win_found) begin
                feat_q <= req_feat[int'(win_idx)*IN_W +: IN_W];
                gnt_q  <= win_idx;
            end
            // The tree has had a full cycle on a registered input, so its output is settled here.
            if (state == EVAL) begin
                cls_q <= dt_outp;
            end
            if (rsp_hs) begin
                rr_ptr <= gnt_q;
                if (done_cnt != {CNT_W{1'b1}}) begin
                    done_cnt <= done_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign dt_inp = feat_q;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_dtc_share_arbiter.sv
// tb/tb_dtc_share_arbiter.sv - directed and random self-checking bench for dtc_share_arbiter
module tb_dtc_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready, req_ready2;
    logic [43:0] req_feat = '0;
    logic [10:0] dt_inp, dt_inp2;
    logic [2:0]  dt_outp, dt_outp2;
    logic [3:0]  rsp_valid, rsp_valid2;
    logic [3:0]  rsp_ready = '0;
    logic [11:0] rsp_class, rsp_class2;
    logic        busy, busy2;
    logic [15:0] done_cnt;
    logic [1:0]  done_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    int   cyc = 0;
    bit   keep_valid = 0;
    bit   rand_mode = 0;
    bit   outst = 0;
    bit   rsp_seen = 0;
    int   out_idx = 0;
    int   acc_cyc = 0;
    int   clr_idx = -1;
    int   n_done = 0;
    int   n_acc = 0;
    logic [2:0] out_cls = '0;
    int   gq[$];
    int   gc[$];

    always #5 clk = ~clk;

    // Reference classifier: a small fixed decision tree.
    function automatic logic [2:0] tree(input logic [10:0] x);
        if (x[5])       return x[0] ? 3'd4 : 3'd3;
        else if (x[10]) return 3'd6;
        else            return {1'b0, x[1:0]};
    endfunction

    assign dt_outp  = tree(dt_inp);
    assign dt_outp2 = tree(dt_inp2);

    dtc_share_arbiter #(.NREQ(4), .IN_W(11), .OUT_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_feat(req_feat), .dt_inp(dt_inp), .dt_outp(dt_outp), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_class(rsp_class), .busy(busy), .done_cnt(done_cnt)
    );

    dtc_share_arbiter #(.NREQ(4), .IN_W(11), .OUT_W(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req_feat(req_feat), .dt_inp(dt_inp2), .dt_outp(dt_outp2), .rsp_valid(rsp_valid2),
        .rsp_ready(rsp_ready), .rsp_class(rsp_class2), .busy(busy2), .done_cnt(done_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_sample();
        int idx;
        @(negedge clk);
        cyc++;
        #1;
        check("done_cnt", done_cnt, 64'(n_done));
        check("done_cnt_sat2", done_cnt2, (n_done > 3) ? 64'd3 : 64'(n_done));
        check("req_ready_onehot", 64'($countones(req_ready) <= 1), 1);
        if (rsp_valid != 0) begin
            if (!outst) begin
                check("spurious_rsp", rsp_valid, 0);
            end else begin
                check("rsp_valid", rsp_valid, 64'(4'b0001 << out_idx));
                check("rsp_class", rsp_class, 64'(12'(out_cls) << (3 * out_idx)));
                if (!rsp_seen) begin
                    check("latency", 64'(cyc - acc_cyc), 2);
                    rsp_seen = 1;
                end
                if (rsp_ready[out_idx]) begin
                    outst = 0;
                    n_done++;
                end
            end
        end
        if (req_ready != 0) begin
            check("accept_while_busy", 64'(outst), 0);
            idx      = $clog2(req_ready);
            outst    = 1;
            out_idx  = idx;
            out_cls  = tree(req_feat[idx*11 +: 11]);
            acc_cyc  = cyc;
            rsp_seen = 0;
            clr_idx  = idx;
            n_acc++;
            gq.push_back(idx);
            gc.push_back(cyc);
        end
    endtask

    task automatic sb_advance();
        @(posedge clk);
        #1;
        if (clr_idx >= 0) begin
            if (!keep_valid) req_valid[clr_idx] = 1'b0;
            clr_idx = -1;
        end
        if (rand_mode) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_valid[i]        = 1'b1;
                    req_feat[i*11 +: 11] = 11'($urandom);
                end
            end
            rsp_ready = 4'($urandom);
        end
    endtask

    task automatic sb_cycle(input int n);
        for (int i = 0; i < n; i++) begin
            sb_sample();
            sb_advance();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req_valid  = '0;
        rsp_ready  = '0;
        keep_valid = 0;
        rand_mode  = 0;
        outst      = 0;
        n_done     = 0;
        n_acc      = 0;
        clr_idx    = -1;
        gq.delete();
        gc.delete();
        #1;
        check("rst_dt_inp", dt_inp, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_class", rsp_class, 0);
        check("rst_busy", busy, 0);
        check("rst_done_cnt", done_cnt, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // single request from requester 0
        do_reset();
        rsp_ready          = 4'hf;
        req_feat[10:0]     = 11'h020;
        req_valid          = 4'b0001;
        sb_sample();
        check("t1_ready", req_ready, 4'b0001);
        sb_advance();
        sb_sample();
        check("t1_busy", busy, 1);
        check("t1_dt_inp", dt_inp, 11'h020);
        check("t1_ready_eval", req_ready, 0);
        sb_advance();
        sb_sample();
        check("t1_rsp_valid", rsp_valid, 4'b0001);
        check("t1_rsp_class", rsp_class, 12'h003);
        sb_advance();
        sb_sample();
        check("t1_done_cnt", done_cnt, 1);
        check("t1_idle", busy, 0);
        sb_advance();

        // simultaneous requests 1 and 2 from reset
        do_reset();
        rsp_ready       = 4'hf;
        req_feat[21:11] = 11'h401;
        req_feat[32:22] = 11'h023;
        req_valid       = 4'b0110;
        sb_cycle(8);
        check("t2_ngrants", gq.size(), 2);
        if (gq.size() == 2) begin
            check("t2_first", gq[0], 1);
            check("t2_second", gq[1], 2);
        end

        // all four continuously valid
        do_reset();
        keep_valid = 1;
        rsp_ready  = 4'hf;
        req_feat   = {11'h003, 11'h401, 11'h021, 11'h020};
        req_valid  = 4'hf;
        sb_cycle(19);
        check("t3_ngrants", 64'(gq.size() >= 6), 1);
        for (int i = 0; i < 6 && i < gq.size(); i++) begin
            check("t3_order", gq[i], i % 4);
            if (i > 0) check("t3_spacing", gc[i] - gc[i-1], 3);
        end

        // response held off, other rsp_ready ignored
        do_reset();
        req_feat[10:0]  = 11'h7ff;
        req_feat[32:22] = 11'h005;
        req_valid       = 4'b0101;
        rsp_ready       = 4'b0010;
        sb_cycle(2);
        for (int i = 0; i < 5; i++) begin
            sb_sample();
            check("t4_hold_valid", rsp_valid, 4'b0001);
            check("t4_hold_class", rsp_class, 12'h004);
            check("t4_hold_ready", req_ready, 0);
            sb_advance();
        end
        rsp_ready = 4'b0001;
        sb_cycle(1);
        sb_sample();
        check("t4_next_grant", req_ready, 4'b0100);
        sb_advance();
        rsp_ready = 4'hf;
        sb_cycle(3);
        check("t4_done", done_cnt, 2);

        // reset while evaluating
        req_feat[10:0] = 11'h020;
        req_valid      = 4'b0001;
        sb_sample();
        check("t5_accept", req_ready, 4'b0001);
        sb_advance();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_dt_inp", dt_inp, 0);
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_rsp_class", rsp_class, 0);
        check("t5_done_cnt", done_cnt, 0);
        outst   = 0;
        n_done  = 0;
        clr_idx = -1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        sb_cycle(6);

        // random traffic against the reference tree
        do_reset();
        rand_mode = 1;
        sb_cycle(300);
        rand_mode = 0;
        rsp_ready = 4'hf;
        sb_cycle(40);
        check("t6_all_served", req_valid, 0);
        check("t6_no_outst", 64'(outst), 0);
        check("t6_no_loss", n_acc, n_done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
